// File: rtl/bitmap_decoder_if.sv
// Command/status bundle for bitmap_decoder: the master issues SET/CLEAR/TOGGLE/CLEAR_ALL
// commands and watches the bitmap state; the slave is the decoder itself.
interface bitmap_decoder_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned IDX_W = $clog2(WIDTH)
);
   logic             valid_i;
   logic [IDX_W-1:0] idx_i;
   logic [1:0]       op_i;
   logic             err_clr_i;
   logic             ready_o;
   logic [WIDTH-1:0] onehot_o;
   logic [WIDTH-1:0] bitmap_o;
   logic [IDX_W:0]   count_o;
   logic             full_o;
   logic             empty_o;
   logic             err_o;

   modport master (
      output valid_i, idx_i, op_i, err_clr_i,
      input  ready_o, onehot_o, bitmap_o, count_o, full_o, empty_o, err_o
   );

   modport slave (
      input  valid_i, idx_i, op_i, err_clr_i,
      output ready_o, onehot_o, bitmap_o, count_o, full_o, empty_o, err_o
   );
endinterface

// File: rtl/bitmap_decoder.sv
// Bitmap register with indexed set/clear/toggle, an incrementally maintained population
// count, a sticky error flag for redundant operations, and a one-cycle flush after CLEAR_ALL.
module bitmap_decoder #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned IDX_W = $clog2(WIDTH)
) (
   input logic              clk_i,
   input logic              rst_ni,
   bitmap_decoder_if.slave  bus
);

   typedef enum logic [0:0] {StIdle, StFlush} state_e;

   localparam logic [1:0] OpSet      = 2'b00;
   localparam logic [1:0] OpClear    = 2'b01;
   localparam logic [1:0] OpToggle   = 2'b10;
   localparam logic [1:0] OpClearAll = 2'b11;

   localparam logic [IDX_W:0]   CountFull = (IDX_W+1)'(WIDTH);
   localparam logic [IDX_W:0]   CountOne  = (IDX_W+1)'(1);
   localparam logic [WIDTH-1:0] OneLsb    = {{(WIDTH-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [WIDTH-1:0] bitmap_q, bitmap_d;
   logic [WIDTH-1:0] onehot_q, onehot_d;
   logic [IDX_W:0]   count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             err_q, err_d;
   logic             err_set;
   logic             idx_ok;
   logic             cur_bit;

   // Only reachable false when WIDTH is not a power of two.
   assign idx_ok  = ({1'b0, bus.idx_i} < CountFull);
   assign cur_bit = idx_ok ? bitmap_q[bus.idx_i] : 1'b0;

   always_comb begin
      state_d  = state_q;
      bitmap_d = bitmap_q;
      onehot_d = onehot_q;
      count_d  = count_q;
      err_set  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.valid_i) begin
               if (bus.op_i == OpClearAll) begin
                  bitmap_d = '0;
                  onehot_d = '0;
                  count_d  = '0;
                  state_d  = StFlush;
               end else if (!idx_ok) begin
                  err_set = 1'b1;
               end else begin
                  onehot_d = OneLsb << bus.idx_i;
                  unique case (bus.op_i)
                     OpSet: begin
                        if (cur_bit) begin
                           err_set = 1'b1;
                        end else begin
                           bitmap_d[bus.idx_i] = 1'b1;
                           count_d             = count_q + CountOne;
                        end
                     end
                     OpClear: begin
                        if (!cur_bit) begin
                           err_set = 1'b1;
                        end else begin
                           bitmap_d[bus.idx_i] = 1'b0;
                           count_d             = count_q - CountOne;
                        end
                     end
                     default: begin
                        bitmap_d[bus.idx_i] = ~cur_bit;
                        count_d = cur_bit ? (count_q - CountOne) : (count_q + CountOne);
                     end
                  endcase
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      full_d  = (count_d == CountFull);
      empty_d = (count_d == '0);
      // A new error outranks a simultaneous clear request.
      err_d   = err_set | (err_q & ~bus.err_clr_i);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         bitmap_q <= '0;
         onehot_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         bitmap_q <= bitmap_d;
         onehot_q <= onehot_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         err_q    <= err_d;
      end
   end

   assign bus.ready_o  = (state_q == StIdle);
   assign bus.bitmap_o = bitmap_q;
   assign bus.onehot_o = onehot_q;
   assign bus.count_o  = count_q;
   assign bus.full_o   = full_q;
   assign bus.empty_o  = empty_q;
   assign bus.err_o    = err_q;

endmodule

// File: tb/tb_bitmap_decoder.sv
// Scoreboard bench for bitmap_decoder: a behavioural model predicts every output after each
// clock edge, predictions are queued at drive time and popped when the outputs are sampled.
module tb_bitmap_decoder;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned IDX_W = 5;

   typedef struct packed {
      logic             ready;
      logic             err;
      logic             full;
      logic             empty;
      logic [IDX_W:0]   count;
      logic [WIDTH-1:0] onehot;
      logic [WIDTH-1:0] bitmap;
   } outs_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bitmap_decoder_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

   bitmap_decoder #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   outs_t exp_q[$];
   int    n_checks = 0;
   int    n_fails  = 0;

   logic [WIDTH-1:0] m_bitmap;
   logic [WIDTH-1:0] m_onehot;
   logic             m_err;
   logic             m_flush;

   function automatic outs_t observe();
      outs_t o;
      o.ready  = bus.ready_o;
      o.err    = bus.err_o;
      o.full   = bus.full_o;
      o.empty  = bus.empty_o;
      o.count  = bus.count_o;
      o.onehot = bus.onehot_o;
      o.bitmap = bus.bitmap_o;
      return o;
   endfunction

   function automatic outs_t model_out();
      outs_t o;
      o.ready  = ~m_flush;
      o.err    = m_err;
      o.count  = (IDX_W+1)'($countones(m_bitmap));
      o.full   = (m_bitmap == '1);
      o.empty  = (m_bitmap == '0);
      o.onehot = m_onehot;
      o.bitmap = m_bitmap;
      return o;
   endfunction

   task automatic model_reset();
      m_bitmap = '0;
      m_onehot = '0;
      m_err    = 1'b0;
      m_flush  = 1'b0;
   endtask

   task automatic model_edge(input logic v, input logic [1:0] op, input logic [IDX_W-1:0] idx,
                             input logic clr);
      logic eset;
      eset = 1'b0;
      if (m_flush) begin
         m_flush = 1'b0;
      end else if (v) begin
         if (op == 2'b11) begin
            m_bitmap = '0;
            m_onehot = '0;
            m_flush  = 1'b1;
         end else begin
            m_onehot      = '0;
            m_onehot[idx] = 1'b1;
            case (op)
               2'b00:   if (m_bitmap[idx]) eset = 1'b1; else m_bitmap[idx] = 1'b1;
               2'b01:   if (!m_bitmap[idx]) eset = 1'b1; else m_bitmap[idx] = 1'b0;
               default: m_bitmap[idx] = ~m_bitmap[idx];
            endcase
         end
      end
      m_err = eset | (m_err & ~clr);
   endtask

   // Drive one cycle of stimulus, queue the prediction, and return just after the edge.
   task automatic drive(input logic v, input logic [1:0] op, input logic [IDX_W-1:0] idx,
                        input logic clr);
      @(negedge clk);
      bus.valid_i   = v;
      bus.op_i      = op;
      bus.idx_i     = idx;
      bus.err_clr_i = clr;
      model_edge(v, op, idx, clr);
      exp_q.push_back(model_out());
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      bus.valid_i   = 1'b0;
      bus.err_clr_i = 1'b0;
      rst_n         = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      outs_t e, got;
      apply_reset();
      exp_q.push_back(model_out());
      e = exp_q.pop_front();
      got = observe();
      n_checks++;
      if (got !== e) begin
         $display("FAIL reset_values got=%h exp=%h", got, e);
         n_fails++;
      end
   endtask

   task automatic test_set();
      outs_t e, got;
      apply_reset();
      drive(1'b1, 2'b00, 5'd5, 1'b0);
      e = exp_q.pop_front();
      got = observe();
      n_checks++;
      if (got !== e || got.bitmap !== 32'h0000_0020 || got.count !== 6'd1) begin
         $display("FAIL set_idx5 got=%h exp=%h", got, e);
         n_fails++;
      end
      repeat (2) begin
         drive(1'b0, 2'b00, 5'd9, 1'b0);
         e = exp_q.pop_front();
         got = observe();
         n_checks++;
         if (got !== e) begin
            $display("FAIL hold_idle got=%h exp=%h", got, e);
            n_fails++;
         end
      end
   endtask

   task automatic test_back_to_back();
      outs_t e, got;
      apply_reset();
      for (int i = 0; i < 32; i++) begin
         drive(1'b1, 2'b00, IDX_W'(i), 1'b0);
         e = exp_q.pop_front();
         got = observe();
         n_checks++;
         if (got !== e) begin
            $display("FAIL fill_step%0d got=%h exp=%h", i, got, e);
            n_fails++;
         end
      end
      n_checks++;
      if (bus.bitmap_o !== 32'hFFFF_FFFF || bus.count_o !== 6'd32 || bus.full_o !== 1'b1 ||
          bus.err_o !== 1'b0) begin
         $display("FAIL fill_final got bitmap=%h count=%0d full=%b err=%b exp ffffffff/32/1/0",
                  bus.bitmap_o, bus.count_o, bus.full_o, bus.err_o);
         n_fails++;
      end
   endtask

   task automatic test_err();
      outs_t e, got;
      logic [1:0]       ops [4] = '{2'b00, 2'b00, 2'b00, 2'b01};
      logic [IDX_W-1:0] idxs[4] = '{5'd7, 5'd7, 5'd0, 5'd3};
      logic             vs  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      logic             clrs[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic             errs[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         drive(vs[i], ops[i], idxs[i], clrs[i]);
         e = exp_q.pop_front();
         got = observe();
         n_checks++;
         if (got !== e || got.err !== errs[i] || got.bitmap !== 32'h80) begin
            $display("FAIL err_step%0d got=%h exp=%h", i, got, e);
            n_fails++;
         end
      end
   endtask

   task automatic test_toggle();
      outs_t e, got;
      apply_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 2'b10, 5'd31, 1'b0);
         e = exp_q.pop_front();
         got = observe();
         n_checks++;
         if (got !== e || got.bitmap !== (i == 0 ? 32'h8000_0000 : 32'h0)) begin
            $display("FAIL toggle31_%0d got=%h exp=%h", i, got, e);
            n_fails++;
         end
      end
   endtask

   task automatic test_clear_all();
      outs_t e, got;
      logic [WIDTH-1:0] pat;
      apply_reset();
      pat = 32'hA5A5_A5A5;
      for (int i = 0; i < 32; i++) begin
         if (pat[i]) begin
            drive(1'b1, 2'b00, IDX_W'(i), 1'b0);
            void'(exp_q.pop_front());
         end
      end
      n_checks++;
      if (bus.bitmap_o !== pat || bus.count_o !== 6'd16) begin
         $display("FAIL preload got=%h/%0d exp=%h/16", bus.bitmap_o, bus.count_o, pat);
         n_fails++;
      end
      drive(1'b1, 2'b11, 5'd0, 1'b0);
      drive(1'b1, 2'b00, 5'd2, 1'b0);
      drive(1'b1, 2'b00, 5'd2, 1'b0);
      for (int i = 0; i < 3; i++) begin
         e = exp_q.pop_front();
         n_checks++;
         if (i == 0) got = e;
         // Only the last sample is still on the outputs; earlier ones are replayed via model.
         if (i == 2) begin
            got = observe();
            if (got !== e || got.bitmap !== 32'h4) begin
               $display("FAIL clear_all_resume got=%h exp=%h", got, e);
               n_fails++;
            end
         end else if (e.ready !== (i != 0) || e.bitmap !== '0) begin
            $display("FAIL clear_all_model_step%0d got=%h exp ready=%0d bitmap=0", i, e, i != 0);
            n_fails++;
         end
      end
   endtask

   task automatic test_flush_ready();
      outs_t e, got;
      apply_reset();
      drive(1'b1, 2'b00, 5'd4, 1'b0);
      void'(exp_q.pop_front());
      drive(1'b1, 2'b11, 5'd0, 1'b0);
      e = exp_q.pop_front();
      got = observe();
      n_checks++;
      if (got !== e || got.ready !== 1'b0 || got.empty !== 1'b1) begin
         $display("FAIL flush_state got=%h exp=%h", got, e);
         n_fails++;
      end
      drive(1'b1, 2'b00, 5'd2, 1'b0);
      e = exp_q.pop_front();
      got = observe();
      n_checks++;
      if (got !== e || got.bitmap !== '0 || got.ready !== 1'b1) begin
         $display("FAIL flush_ignores_cmd got=%h exp=%h", got, e);
         n_fails++;
      end
   endtask

   task automatic test_reset_flush();
      outs_t e, got;
      apply_reset();
      drive(1'b1, 2'b00, 5'd12, 1'b1);
      void'(exp_q.pop_front());
      drive(1'b1, 2'b11, 5'd0, 1'b0);
      void'(exp_q.pop_front());
      @(negedge clk);
      bus.valid_i = 1'b0;
      rst_n = 1'b0;
      model_reset();
      exp_q.push_back(model_out());
      #1;
      e = exp_q.pop_front();
      got = observe();
      n_checks++;
      if (got !== e) begin
         $display("FAIL async_reset_in_flush got=%h exp=%h", got, e);
         n_fails++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 2'b00, 5'd9, 1'b0);
      void'(exp_q.pop_front());
      @(negedge clk);
      bus.valid_i = 1'b1;
      bus.op_i    = 2'b00;
      bus.idx_i   = 5'd1;
      rst_n       = 1'b0;
      model_reset();
      exp_q.push_back(model_out());
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      got = observe();
      n_checks++;
      if (got !== e) begin
         $display("FAIL reset_beats_cmd got=%h exp=%h", got, e);
         n_fails++;
      end
      @(negedge clk);
      bus.valid_i = 1'b0;
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (bus.ready_o !== 1'b1) begin
         $display("FAIL ready_after_release got=%b exp=1", bus.ready_o);
         n_fails++;
      end
   endtask

   initial begin
      bus.valid_i   = 1'b0;
      bus.op_i      = 2'b00;
      bus.idx_i     = '0;
      bus.err_clr_i = 1'b0;
      model_reset();
      test_reset();
      test_set();
      test_back_to_back();
      test_err();
      test_toggle();
      test_flush_ready();
      test_clear_all();
      test_reset_flush();
      n_checks++;
      if (exp_q.size() != 0) begin
         $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
         n_fails++;
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/bitmap_decoder.md
BITMAP_DECODER -- requirements
Module: bitmap_decoder

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the number of bitmap entries (power of two, 2..32).
REQ-002 The block SHALL have parameter IDX_W, default $clog2(WIDTH) = 5, giving the index width.

Interface
REQ-003 The block SHALL use a single clock and an asynchronous, active-low reset.
REQ-004 clk_i  input  1  clock; all state changes on the rising edge.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 valid_i  input  1  command valid.
REQ-007 idx_i  input  IDX_W  binary index to decode.
REQ-008 op_i  input  2  command: 00 SET, 01 CLEAR, 10 TOGGLE, 11 CLEAR_ALL (idx_i ignored).
REQ-009 ready_o  output  1  block can accept a command.
REQ-010 err_clr_i  input  1  clears the sticky error flag.
REQ-011 onehot_o  output  WIDTH  registered one-hot decode of the last accepted idx_i; zero after CLEAR_ALL.
REQ-012 bitmap_o  output  WIDTH  current bitmap register.
REQ-013 count_o  output  IDX_W+1  number of set bits in bitmap_o.
REQ-014 full_o  output  1  all bitmap bits set.
REQ-015 empty_o  output  1  no bitmap bits set.
REQ-016 err_o  output  1  sticky redundant-operation flag.

Function
REQ-017 A command SHALL be accepted only on a rising edge where valid_i and ready_o are both 1.
REQ-018 Results of a command accepted at edge N SHALL be visible on all outputs immediately after edge N; latency is one cycle from valid_i to output.
REQ-019 SET SHALL write bitmap[idx_i]=1, CLEAR SHALL write 0, and TOGGLE SHALL invert it; onehot_o SHALL be 1<<idx_i.
REQ-020 count_o SHALL be maintained incrementally: +1 on a 0->1 change, -1 on a 1->0 change, unchanged otherwise; it SHALL never wrap.
REQ-021 full_o SHALL equal (count_o==WIDTH), and empty_o SHALL equal (count_o==0); both are registered with count_o.
REQ-022 A SET to an already-set bit or a CLEAR to an already-clear bit SHALL leave bitmap_o and count_o unchanged and SHALL set err_o.
REQ-023 If err_clr_i and a new error occur in the same cycle, err_o SHALL remain 1 (set wins).
REQ-024 The FSM SHALL have two states, IDLE and FLUSH; ready_o=1 only in IDLE.
REQ-025 An accepted CLEAR_ALL SHALL move IDLE->FLUSH, zero bitmap_o, count_o and onehot_o, and set empty_o=1 at that edge.
REQ-026 FLUSH SHALL return to IDLE unconditionally after exactly one cycle; valid_i in FLUSH SHALL be ignored and the command held by the source.
REQ-027 An idx_i >= WIDTH (only possible for non-power-of-two use) SHALL be rejected: accepted, no state change, err_o set.
REQ-028 Outputs SHALL hold their values when no command is accepted.

Reset
REQ-029 On rst_ni low, asynchronously: bitmap_o=0, onehot_o=0, count_o=0, empty_o=1, full_o=0, err_o=0, FSM=IDLE, ready_o=1.
REQ-030 Reset asserted mid-FLUSH or coincident with a command SHALL win; the command SHALL be discarded.

Verification
REQ-031 Reset then SET idx 5 -> next cycle bitmap_o=0x00000020, onehot_o=0x00000020, count_o=1, empty_o=0.
REQ-032 SET idx 0..31 back-to-back -> after 32 cycles bitmap_o=0xFFFFFFFF, count_o=32, full_o=1, err_o=0.
REQ-033 SET 7, SET 7 -> bitmap_o=0x80, count_o=1, err_o=1; err_clr_i pulse -> err_o=0; err_clr_i coincident with CLEAR 3 (clear bit) -> err_o=1.
REQ-034 TOGGLE 31 twice from reset -> 0x80000000/count 1, then 0/count 0/empty_o 1.
REQ-035 CLEAR_ALL with bitmap 0xA5A5A5A5 -> next cycle bitmap_o=0, count_o=0, ready_o=0 for 1 cycle; a SET 2 held valid is accepted the following cycle.
REQ-036 Assert rst_ni low during FLUSH -> all outputs at REQ-029 values asynchronously, ready_o=1 after release.
